// File: rtl/uart_frame_decoder_if.sv
// uart_frame_decoder_if: groups the byte-receiver input, the payload stream
// and the error pulses of uart_frame_decoder.
//   master : environment side (drives bytes and ready, observes the stream)
//   slave  : decoder side
interface uart_frame_decoder_if;
  logic       new_data_in;
  logic [7:0] data_byte_in;
  logic [7:0] frame_byte_out;
  logic       frame_valid_out;
  logic       frame_ready_in;
  logic       frame_last_out;
  logic [7:0] frame_len_out;
  logic       crc_err_out;
  logic       len_err_out;
  logic       drop_out;
  logic       timeout_out;

  modport master (
    output new_data_in, data_byte_in, frame_ready_in,
    input  frame_byte_out, frame_valid_out, frame_last_out, frame_len_out,
           crc_err_out, len_err_out, drop_out, timeout_out
  );

  modport slave (
    input  new_data_in, data_byte_in, frame_ready_in,
    output frame_byte_out, frame_valid_out, frame_last_out, frame_len_out,
           crc_err_out, len_err_out, drop_out, timeout_out
  );
endinterface

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: hunts for SYNC_BYTE, reads LEN, buffers LEN payload
// bytes, verifies an 8-bit additive checksum (LEN + payload + CHK == 0 mod 256)
// and replays good payloads as a valid/ready stream with a last flag.
// Ports:
//   clk_in, rst_in : clock, asynchronous active-high reset
//   bus (slave)    : new_data_in/data_byte_in from the UART receiver,
//                    frame_* payload stream, crc/len/drop/timeout pulses
// Optional feature: define UART_FRAME_TIMEOUT_EN to add an inter-byte timeout
// (TIMEOUT_CYCLES) while a frame is being received; otherwise timeout_out = 0.
module uart_frame_decoder #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_PAYLOAD = 16
`ifdef UART_FRAME_TIMEOUT_EN
  , parameter int       TIMEOUT_CYCLES = 100_000
`endif
) (
  input  logic          clk_in,
  input  logic          rst_in,
  uart_frame_decoder_if.slave bus
);
  localparam int IW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHECK, S_DRAIN} state_t;

  state_t        state, state_n;
  logic [7:0]    mem [MAX_PAYLOAD];
  logic [IW-1:0] idx, rd, len_m1;   // LEN is stored as LEN-1 so it fits the index width
  logic [7:0]    sum, frame_len;
  logic          crc_q, len_q, drop_q;
  logic          crc_n, len_n, drop_n;

  logic          strobe, len_bad, valid, xfer, at_last, active, expire;
  logic [7:0]    din, chk_sum;

  assign strobe  = bus.new_data_in;
  assign din     = bus.data_byte_in;
  assign len_bad = (din == 8'h00) || (int'(din) > MAX_PAYLOAD);
  assign chk_sum = sum + din;
  assign valid   = (state == S_DRAIN);
  assign xfer    = valid && bus.frame_ready_in;
  assign at_last = (rd == len_m1);
  assign active  = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHECK);

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr;
  logic          to_q;

  // A strobe on the expiry cycle wins, so expiry requires no strobe.
  assign expire = active && !strobe && (tmr == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tmr  <= '0;
      to_q <= 1'b0;
    end else begin
      to_q <= expire;
      if (strobe || !active || expire) tmr <= '0;
      else                             tmr <= tmr + 1'b1;
    end
  end
  assign bus.timeout_out = to_q;
`else
  assign expire          = 1'b0;
  assign bus.timeout_out = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= S_HUNT;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    crc_n   = 1'b0;
    len_n   = 1'b0;
    drop_n  = 1'b0;
    case (state)
      S_HUNT:    if (strobe && din == SYNC_BYTE) state_n = S_LEN;
      S_LEN:     if (strobe) begin
                   if (len_bad) begin len_n = 1'b1; state_n = S_HUNT; end
                   else state_n = S_PAYLOAD;
                 end
      S_PAYLOAD: if (strobe && idx == len_m1) state_n = S_CHECK;
      S_CHECK:   if (strobe) begin
                   if (chk_sum == 8'h00) state_n = S_DRAIN;
                   else begin crc_n = 1'b1; state_n = S_HUNT; end
                 end
      S_DRAIN:   begin
                   // Bytes cannot be buffered while replaying; they are dropped.
                   drop_n = strobe;
                   if (xfer && at_last) state_n = S_HUNT;
                 end
      default:   state_n = S_HUNT;
    endcase
    if (expire) state_n = S_HUNT;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      idx       <= '0;
      rd        <= '0;
      len_m1    <= '0;
      sum       <= '0;
      frame_len <= '0;
      crc_q     <= 1'b0;
      len_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      crc_q  <= crc_n;
      len_q  <= len_n;
      drop_q <= drop_n;
      if (strobe) begin
        case (state)
          S_LEN:     if (!len_bad) begin
                       len_m1 <= IW'(din - 8'd1);
                       sum    <= din;
                       idx    <= '0;
                     end
          S_PAYLOAD: begin
                       sum <= sum + din;
                       if (idx != len_m1) idx <= idx + 1'b1;
                     end
          S_CHECK:   if (chk_sum == 8'h00) begin
                       rd        <= '0;
                       frame_len <= 8'(len_m1) + 8'd1;
                     end
          default:   ;
        endcase
      end
      if (xfer && !at_last) rd <= rd + 1'b1;
    end
  end

  // Payload storage needs no reset; the output mux gates it when not draining.
  always_ff @(posedge clk_in) begin
    if (strobe && state == S_PAYLOAD) mem[idx] <= din;
  end

  assign bus.frame_valid_out = valid;
  assign bus.frame_byte_out  = valid ? mem[rd] : 8'h00;
  assign bus.frame_last_out  = valid && at_last;
  assign bus.frame_len_out   = frame_len;
  assign bus.crc_err_out     = crc_q;
  assign bus.len_err_out     = len_q;
  assign bus.drop_out        = drop_q;
endmodule

// File: tb/tb_uart_frame_decoder.sv
module tb_uart_frame_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_frame_decoder_if bus();

`ifdef UART_FRAME_TIMEOUT_EN
  uart_frame_decoder #(.SYNC_BYTE(8'hA5), .MAX_PAYLOAD(16), .TIMEOUT_CYCLES(50)) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus));
`else
  uart_frame_decoder #(.SYNC_BYTE(8'hA5), .MAX_PAYLOAD(16)) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus));
`endif

  int nvec = 0;
  int nerr = 0;

  // Monitor: records every handshake and counts every pulse cycle.
  logic [7:0] cap_b[$];
  logic       cap_l[$];
  logic [7:0] cap_n[$];
  int n_crc = 0, n_len = 0, n_drop = 0, n_to = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.frame_valid_out && bus.frame_ready_in) begin
        cap_b.push_back(bus.frame_byte_out);
        cap_l.push_back(bus.frame_last_out);
        cap_n.push_back(bus.frame_len_out);
      end
      if (bus.crc_err_out) n_crc++;
      if (bus.len_err_out) n_len++;
      if (bus.drop_out)    n_drop++;
      if (bus.timeout_out) n_to++;
    end
  end

  // Reference expectations: payloads of frames that should be replayed.
  logic [7:0] exp_b[$];
  logic       exp_l[$];
  logic [7:0] exp_n[$];
  int exp_crc, exp_len;

  typedef struct {
    logic [63:0] seq;    // bytes MSB first
    int          n;
    logic [31:0] out;    // expected payload, MSB first
    int          out_n;
    int          crc;
    int          lerr;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.new_data_in  = 1'b1;
    bus.data_byte_in = b;
    tick();
    bus.new_data_in  = 1'b0;
  endtask

  task automatic wait_drain(input bit rnd);
    int n = 0;
    while (bus.frame_valid_out && n < 400) begin
      if (rnd) bus.frame_ready_in = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    bus.frame_ready_in = 1'b1;
    if (n >= 400) chk("drain_timeout", n, 0);
  endtask

  task automatic send_seq(input logic [7:0] s[$], input bit rnd);
    foreach (s[i]) begin
      send_byte(s[i]);
      if (bus.frame_valid_out) wait_drain(rnd);
    end
  endtask

  task automatic model_good(input logic [7:0] p[$]);
    foreach (p[i]) begin
      exp_b.push_back(p[i]);
      exp_l.push_back(i == p.size() - 1);
      exp_n.push_back(8'(p.size()));
    end
  endtask

  task automatic cmp_stream(input string tag, input int mark);
    chk({tag, "_count"}, cap_b.size() - mark, exp_b.size());
    for (int i = 0; i < exp_b.size() && mark + i < cap_b.size(); i++) begin
      chk({tag, "_byte"}, cap_b[mark+i], exp_b[i]);
      chk({tag, "_last"}, cap_l[mark+i], exp_l[i]);
      chk({tag, "_len"},  cap_n[mark+i], exp_n[i]);
    end
    exp_b.delete(); exp_l.delete(); exp_n.delete();
  endtask

  initial begin
    logic [7:0] s[$];
    logic [7:0] p[$];
    int mark, mc, ml, md, mt;

    bus.new_data_in    = 1'b0;
    bus.data_byte_in   = 8'h00;
    bus.frame_ready_in = 1'b1;

    tbl[0] = '{{8'hA5,8'h03,8'h11,8'h22,8'h33,8'h97,16'h0}, 6, {8'h11,8'h22,8'h33,8'h00}, 3, 0, 0};
    tbl[1] = '{{8'hA5,8'h03,8'h11,8'h22,8'h33,8'h98,16'h0}, 6, 32'h0, 0, 1, 0};
    tbl[2] = '{{8'hA5,8'h03,8'h11,8'h22,8'h33,8'h97,16'h0}, 6, {8'h11,8'h22,8'h33,8'h00}, 3, 0, 0};
    tbl[3] = '{{8'hA5,8'h00,48'h0}, 2, 32'h0, 0, 0, 1};
    tbl[4] = '{{8'hA5,8'h11,48'h0}, 2, 32'h0, 0, 0, 1};
    tbl[5] = '{{8'h00,8'hFF,8'hA5,8'h01,8'h7F,8'h80,16'h0}, 6, {8'h7F,24'h0}, 1, 0, 0};
    tbl[6] = '{{8'hA5,8'h02,8'hA5,8'hA5,8'hB4,24'h0}, 5, {8'hA5,8'hA5,16'h0}, 2, 0, 0};

    // Reset state
    tick(); tick();
    chk("rst_valid", bus.frame_valid_out, 0);
    chk("rst_byte",  bus.frame_byte_out, 0);
    chk("rst_last",  bus.frame_last_out, 0);
    chk("rst_len",   bus.frame_len_out, 0);
    chk("rst_crc",   bus.crc_err_out, 0);
    chk("rst_lenerr", bus.len_err_out, 0);
    chk("rst_drop",  bus.drop_out, 0);
    chk("rst_to",    bus.timeout_out, 0);
    rst = 1'b0;
    tick();

    // Table-driven frames, ready held high
    for (int v = 0; v < 7; v++) begin
      mark = cap_b.size(); mc = n_crc; ml = n_len; md = n_drop; mt = n_to;
      s.delete(); p.delete();
      for (int j = 0; j < tbl[v].n; j++) s.push_back(tbl[v].seq[63-8*j -: 8]);
      for (int j = 0; j < tbl[v].out_n; j++) p.push_back(tbl[v].out[31-8*j -: 8]);
      model_good(p);
      send_seq(s, 1'b0);
      tick(); tick();
      cmp_stream($sformatf("vec%0d", v), mark);
      chk($sformatf("vec%0d_crc", v),  n_crc - mc, tbl[v].crc);
      chk($sformatf("vec%0d_lenerr", v), n_len - ml, tbl[v].lerr);
      chk($sformatf("vec%0d_drop", v), n_drop - md, 0);
      chk($sformatf("vec%0d_to", v),   n_to - mt, 0);
    end

    // Backpressure: junk, then 1-byte frame held 5 cycles with last=1
    bus.frame_ready_in = 1'b0;
    mark = cap_b.size();
    s = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7F, 8'h80};
    foreach (s[i]) send_byte(s[i]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", bus.frame_valid_out, 1);
      chk("hold_byte",  bus.frame_byte_out, 8'h7F);
      chk("hold_last",  bus.frame_last_out, 1);
      @(posedge clk); #1;
    end
    bus.frame_ready_in = 1'b1;
    tick();
    @(negedge clk);
    chk("hold_drop_valid", bus.frame_valid_out, 0);
    chk("hold_len", bus.frame_len_out, 1);
    @(posedge clk); #1;
    chk("hold_count", cap_b.size() - mark, 1);

    // Drop during drain, including a strobe on the final handshake cycle
    mark = cap_b.size(); mc = n_crc; ml = n_len; md = n_drop;
    bus.frame_ready_in = 1'b0;
    s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    foreach (s[i]) send_byte(s[i]);
    send_byte(8'h44);
    tick();
    chk("drop_once", n_drop - md, 1);
    bus.frame_ready_in = 1'b1;
    tick(); tick();
    bus.frame_ready_in = 1'b0;
    tick();
    bus.frame_ready_in = 1'b1;
    send_byte(8'hA5);          // lands with the last handshake: must be dropped
    chk("drop_last_valid", bus.frame_valid_out, 0);
    s = '{8'h01, 8'h7F, 8'h80}; // would form a frame had the A5 been taken
    send_seq(s, 1'b0);
    tick(); tick();
    p = '{8'h11, 8'h22, 8'h33};
    model_good(p);
    cmp_stream("drop", mark);
    chk("drop_total", n_drop - md, 2);
    chk("drop_crc", n_crc - mc, 0);
    chk("drop_lenerr", n_len - ml, 0);

    // Reset mid-drain and mid-frame
    bus.frame_ready_in = 1'b0;
    s = '{8'hA5, 8'h01, 8'h7F, 8'h80};
    foreach (s[i]) send_byte(s[i]);
    chk("rdrain_valid_pre", bus.frame_valid_out, 1);
    rst = 1'b1; #1;
    chk("rdrain_valid", bus.frame_valid_out, 0);
    chk("rdrain_byte",  bus.frame_byte_out, 0);
    chk("rdrain_len",   bus.frame_len_out, 0);
    tick(); rst = 1'b0; bus.frame_ready_in = 1'b1; tick();
    mark = cap_b.size(); mc = n_crc; ml = n_len; md = n_drop;
    s = '{8'hA5, 8'h03, 8'h11};
    foreach (s[i]) send_byte(s[i]);
    rst = 1'b1; tick(); rst = 1'b0; tick();
    s = '{8'hA5, 8'h01, 8'h7F, 8'h80};
    send_seq(s, 1'b0);
    tick(); tick();
    p = '{8'h7F};
    model_good(p);
    cmp_stream("rframe", mark);
    chk("rframe_pulses", (n_crc - mc) + (n_len - ml) + (n_drop - md), 0);

`ifdef UART_FRAME_TIMEOUT_EN
    begin
      int first, cnt;
      first = -1; cnt = 0;
      mark = cap_b.size(); mc = n_crc; ml = n_len;
      s = '{8'hA5, 8'h02, 8'h11};
      foreach (s[i]) send_byte(s[i]);
      for (int g = 1; g <= 60; g++) begin
        @(posedge clk); @(negedge clk);
        if (bus.timeout_out) begin
          cnt++;
          if (first < 0) first = g;
        end
      end
      @(posedge clk); #1;
      chk("to_count", cnt, 1);
      chk("to_cycle", first, 50);
      s = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'hCE};
      send_seq(s, 1'b0);
      tick(); tick();
      p = '{8'h10, 8'h20};
      model_good(p);
      cmp_stream("to_after", mark);
      chk("to_other", (n_crc - mc) + (n_len - ml), 0);
    end
`endif

    // Randomized frames with random backpressure against a frame-level model
    mark = cap_b.size(); mc = n_crc; ml = n_len; md = n_drop; mt = n_to;
    exp_crc = 0; exp_len = 0;
    for (int k = 0; k < 40; k++) begin
      int kind, L, sm;
      logic [7:0] b, chk_b;
      s.delete(); p.delete();
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        s.push_back(b);
      end
      kind = $urandom_range(0, 3);
      if (k < 3) kind = 2;
      if (kind == 0) begin
        L = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(17, 255);
        s.push_back(8'hA5); s.push_back(8'(L));
        exp_len++;
      end else begin
        L = (k == 0) ? 16 : (k == 1) ? 1 : $urandom_range(1, 16);
        sm = L;
        for (int j = 0; j < L; j++) begin
          b = 8'($urandom);
          p.push_back(b);
          sm += b;
        end
        chk_b = 8'(256 - (sm % 256));
        if (kind == 1) begin
          chk_b = chk_b + 8'($urandom_range(1, 255));
          exp_crc++;
        end else begin
          model_good(p);
        end
        s.push_back(8'hA5); s.push_back(8'(L));
        foreach (p[j]) s.push_back(p[j]);
        s.push_back(chk_b);
      end
      send_seq(s, 1'b1);
    end
    tick(); tick();
    cmp_stream("rand", mark);
    chk("rand_crc", n_crc - mc, exp_crc);
    chk("rand_lenerr", n_len - ml, exp_len);
    chk("rand_drop", n_drop - md, 0);
    chk("rand_to", n_to - mt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
